axi_lite_lfsr_mgr: RTL and testbench
====================================

Name: axi_lite_lfsr_mgr

Overview:
AXI4-Lite manager (initiator) traffic generator and checker; the initiator counterpart of the LFSR subordinates.
On start, it writes NumTxns pseudo-random words, generated by a 32-bit Galois LFSR, to consecutive word addresses from BaseAddr.
It then reseeds, reads the same addresses back, and compares each read against the regenerated LFSR sequence.
Used in testbenches and BIST wrappers to exercise memories and interconnect behind an AXI-Lite port.

Parameters:
DataWidth, 32, AXI-Lite data width; legal values 32 or 64.
AddrWidth, 32, AXI-Lite address width.
NumTxns, 16, words per write pass and per read pass; minimum 1.
BaseAddr, 0, byte address of the first word; must be aligned to DataWidth/8.
Seed, 32'h0000_0001, LFSR seed; a value of 0 is replaced by 1.
axi_lite_req_t, logic, AXI-Lite request struct type.
axi_lite_rsp_t, logic, AXI-Lite response struct type.

Ports:
clk_i  in  1  rising-edge clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  pulse; starts a run when in IDLE, ignored otherwise
busy_o  out  1  high from the cycle after start is accepted until DONE
done_o  out  1  one-cycle pulse when the run completes
err_cnt_o  out  16  mismatches plus non-OKAY responses, saturating at 16'hFFFF
cycles_o  out  32  run cycle count (optional feature)
req_o  out  axi_lite_req_t  AXI-Lite request
rsp_i  in  axi_lite_rsp_t  AXI-Lite response

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: FSM=IDLE, all valid/ready outputs 0, busy_o=0, done_o=0, err_cnt_o=0, cycles_o=0, idx=0, LFSR=Seed (or 1 if Seed is 0).
- All req_o fields are registered; no combinational path from rsp_i to req_o.
- LFSR: right-shift Galois, mask 32'h8020_0003.
  - next = {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 0).
  - Word data: DataWidth=32 gives s; DataWidth=64 gives {s, s}.
  - The LFSR advances once per completed word in each pass.
- Address: BaseAddr + idx*(DataWidth/8), truncated to AddrWidth (wraps modulo 2^AddrWidth). aw.prot and ar.prot = 3'b000. w.strb = all ones.
- FSM states:
  - IDLE: start_i=1 clears err_cnt and idx, loads the seed, and goes to WR_ADDR.
  - WR_ADDR:
    - aw_valid and w_valid are asserted together the cycle after entry.
    - Each valid drops after its own handshake; the two are tracked by aw_done and w_done flags.
    - Once both handshakes are done, go to WR_RESP.
  - WR_RESP:
    - b_ready=1.
    - On the b handshake: if b.resp != OKAY, err_cnt is incremented.
    - Advance the LFSR and idx.
    - If idx was NumTxns-1: go to RD_ADDR with idx=0 and the LFSR reloaded with the seed. Otherwise return to WR_ADDR.
  - RD_ADDR: ar_valid=1 until the handshake, then go to RD_RESP.
  - RD_RESP:
    - r_ready=1.
    - On the r handshake: err_cnt increments by exactly 1 if r.data != expected OR r.resp != OKAY.
    - Advance the LFSR and idx.
    - After the last word, go to DONE.
  - DONE: done_o=1 for one cycle, busy_o=0 next cycle, then IDLE.
- Outstanding transactions: exactly one at a time per channel pair; no new AW/W is issued before B, and no new AR before R.
- Valid stability: once asserted, a valid and its payload are held stable until the handshake (AXI rule).
- Handshake timing: a handshake in the same cycle as valid assertion is accepted. Simultaneous AW and W handshakes are allowed.
- err_cnt_o saturates at 16'hFFFF and is held after DONE until the next start.
- Reset mid-run: returns to the reset state immediately. Outstanding bus transactions are abandoned; the environment must also be reset.
- start_i while busy is ignored.

Optional Feature:
Macro AXI_LITE_LFSR_MGR_PERF_EN.
- Defined:
  - cycles_o is a 32-bit counter, cleared on an accepted start_i.
  - It increments every cycle while busy_o=1, saturating at 32'hFFFF_FFFF.
  - It holds its value after DONE.
- Undefined: cycles_o is tied to 0 and no counter logic is generated.

Test Plan:
- Reset, then an ideal memory responder (always ready, OKAY), NumTxns=4, Seed=1 -> writes to 0x0, 0x4, 0x8, 0xC with data 0x0000_0001, 0x8020_0003, 0xC030_0002, 0x6018_0001. Reads return the same words, err_cnt_o=0, done_o pulses once.
- Same setup with the memory corrupting the read at 0x8 (bit 0 flipped) -> err_cnt_o=1.
- Same setup with the memory returning SLVERR on the B for 0x4 and on the R for 0xC -> err_cnt_o=2.
- Responder with AW ready delayed 3 cycles and W ready immediate -> w_valid drops after 1 cycle, aw_valid holds 3 cycles with a stable payload, and exactly one B is awaited per word.
- Seed=0 -> first write data is 0x0000_0001. start_i pulsed while busy -> no effect on the run.
- With AXI_LITE_LFSR_MGR_PERF_EN defined and an always-ready responder, NumTxns=1 -> cycles_o equals the measured busy_o-high cycle count.
- Reset asserted mid WR_ADDR -> all valids are 0 and busy_o=0 asynchronously.

Source files
------------

// File: rtl/axi_lite_lfsr_mgr.sv
// axi_lite_lfsr_mgr: AXI4-Lite manager that writes an LFSR word sequence, then reads it back and checks it.
// Optional run-cycle counter on cycles_o is built only when AXI_LITE_LFSR_MGR_PERF_EN is defined.

package axi_lite_lfsr_mgr_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  prot;
   } aw_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
   } w_chan_t;

   typedef struct packed {
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  prot;
   } ar_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic     aw_ready;
      logic     w_ready;
      b_chan_t  b;
      logic     b_valid;
      logic     ar_ready;
      r_chan_t  r;
      logic     r_valid;
   } rsp_t;

endpackage

module axi_lite_lfsr_mgr #(
   parameter int unsigned          DataWidth = 32,
   parameter int unsigned          AddrWidth = 32,
   parameter int unsigned          NumTxns   = 16,
   parameter logic [AddrWidth-1:0] BaseAddr  = '0,
   parameter logic [31:0]          Seed      = 32'h0000_0001,
   parameter type                  axi_lite_req_t = axi_lite_lfsr_mgr_pkg::req_t,
   parameter type                  axi_lite_rsp_t = axi_lite_lfsr_mgr_pkg::rsp_t
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [15:0]   err_cnt_o,
   output logic [31:0]   cycles_o,
   output axi_lite_req_t req_o,
   input  axi_lite_rsp_t rsp_i
);

   localparam int unsigned          IdxW      = (NumTxns > 1) ? $clog2(NumTxns) : 1;
   localparam logic [IdxW-1:0]      LastIdx   = IdxW'(NumTxns - 1);
   localparam logic [AddrWidth-1:0] WordBytes = AddrWidth'(DataWidth / 8);
   localparam logic [31:0]          LfsrMask  = 32'h8020_0003;
   // An all-zero seed would lock the LFSR at zero forever, so it is replaced by 1.
   localparam logic [31:0]          SeedEff   = (Seed == 32'h0) ? 32'h0000_0001 : Seed;
   localparam logic [1:0]           RespOkay  = 2'b00;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_RESP,
      RD_ADDR,
      RD_RESP,
      DONE
   } state_e;

   state_e          state_q, state_d;
   axi_lite_req_t   req_q, req_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [31:0]     lfsr_q, lfsr_d;
   logic [15:0]     err_q, err_d;
   logic            aw_done_q, aw_done_d;
   logic            w_done_q, w_done_d;
   logic            issue_wr, issue_rd, err_inc, last_word;
   logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LfsrMask : 32'h0);
   endfunction

   function automatic logic [DataWidth-1:0] word_of(input logic [31:0] s);
      return {(DataWidth / 32){s}};
   endfunction

   function automatic logic [AddrWidth-1:0] word_addr(input logic [IdxW-1:0] i);
      return BaseAddr + AddrWidth'(i) * WordBytes;
   endfunction

   assign aw_hs     = req_q.aw_valid & rsp_i.aw_ready;
   assign w_hs      = req_q.w_valid  & rsp_i.w_ready;
   assign b_hs      = req_q.b_ready  & rsp_i.b_valid;
   assign ar_hs     = req_q.ar_valid & rsp_i.ar_ready;
   assign r_hs      = req_q.r_ready  & rsp_i.r_valid;
   assign last_word = (idx_q == LastIdx);

   // Next-state and next-request logic; every request field is computed here and registered below,
   // so a new beat's payload is derived from the already-advanced index and LFSR value.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      idx_d     = idx_q;
      lfsr_d    = lfsr_q;
      err_d     = err_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      issue_wr  = 1'b0;
      issue_rd  = 1'b0;
      err_inc   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               err_d    = '0;
               idx_d    = '0;
               lfsr_d   = SeedEff;
               issue_wr = 1'b1;
               state_d  = WR_ADDR;
            end
         end

         WR_ADDR: begin
            if (aw_hs) begin
               req_d.aw_valid = 1'b0;
               aw_done_d      = 1'b1;
            end
            if (w_hs) begin
               req_d.w_valid = 1'b0;
               w_done_d      = 1'b1;
            end
            if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
               req_d.b_ready = 1'b1;
               state_d       = WR_RESP;
            end
         end

         WR_RESP: begin
            if (b_hs) begin
               req_d.b_ready = 1'b0;
               err_inc       = (rsp_i.b.resp != RespOkay);
               if (last_word) begin
                  idx_d    = '0;
                  lfsr_d   = SeedEff;
                  issue_rd = 1'b1;
                  state_d  = RD_ADDR;
               end else begin
                  idx_d    = idx_q + IdxW'(1);
                  lfsr_d   = lfsr_next(lfsr_q);
                  issue_wr = 1'b1;
                  state_d  = WR_ADDR;
               end
            end
         end

         RD_ADDR: begin
            if (ar_hs) begin
               req_d.ar_valid = 1'b0;
               req_d.r_ready  = 1'b1;
               state_d        = RD_RESP;
            end
         end

         RD_RESP: begin
            if (r_hs) begin
               req_d.r_ready = 1'b0;
               err_inc       = (rsp_i.r.data != word_of(lfsr_q)) || (rsp_i.r.resp != RespOkay);
               lfsr_d        = lfsr_next(lfsr_q);
               if (last_word) begin
                  idx_d   = '0;
                  state_d = DONE;
               end else begin
                  idx_d    = idx_q + IdxW'(1);
                  issue_rd = 1'b1;
                  state_d  = RD_ADDR;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (issue_wr) begin
         req_d.aw.addr  = word_addr(idx_d);
         req_d.aw.prot  = 3'b000;
         req_d.aw_valid = 1'b1;
         req_d.w.data   = word_of(lfsr_d);
         req_d.w.strb   = '1;
         req_d.w_valid  = 1'b1;
         aw_done_d      = 1'b0;
         w_done_d       = 1'b0;
      end

      if (issue_rd) begin
         req_d.ar.addr  = word_addr(idx_d);
         req_d.ar.prot  = 3'b000;
         req_d.ar_valid = 1'b1;
      end

      // The error counter sticks at its maximum rather than wrapping back to a clean-looking value.
      if (err_inc && (err_q != 16'hFFFF)) begin
         err_d = err_q + 16'd1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request, index, LFSR and error registers; a reset abandons any bus transaction in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_q     <= '0;
         idx_q     <= '0;
         lfsr_q    <= SeedEff;
         err_q     <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         req_q     <= req_d;
         idx_q     <= idx_d;
         lfsr_q    <= lfsr_d;
         err_q     <= err_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign req_o     = req_q;
   assign busy_o    = (state_q != IDLE);
   assign done_o    = (state_q == DONE);
   assign err_cnt_o = err_q;

`ifdef AXI_LITE_LFSR_MGR_PERF_EN
   logic [31:0] cycles_q;

   // Counts every busy cycle of the current run, saturating, and holds the total once idle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycles_q <= '0;
      end else if ((state_q == IDLE) && start_i) begin
         cycles_q <= '0;
      end else if (busy_o && (cycles_q != 32'hFFFF_FFFF)) begin
         cycles_q <= cycles_q + 32'd1;
      end
   end

   assign cycles_o = cycles_q;
`else
   assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_axi_lite_lfsr_mgr.sv
// tb_axi_lite_lfsr_mgr: scoreboard bench with a configurable AXI-Lite memory responder.
// A second instance (Seed=0, NumTxns=1) covers seed substitution and the optional cycle counter.
module tb_axi_lite_lfsr_mgr;
   import axi_lite_lfsr_mgr_pkg::*;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n, start, start0;
   logic        busy, done, busy0, done0;
   logic [15:0] err_cnt, err_cnt0;
   logic [31:0] cycles, cycles0;
   req_t        req, req0;
   rsp_t        rsp, rsp0;

   int n_checks = 0;
   int n_pass   = 0;

   // responder configuration
   int          aw_delay;
   bit          corrupt_en, slverr_b_en, slverr_r_en;
   logic [31:0] corrupt_addr, slverr_b_addr, slverr_r_addr;

   // responder state
   logic [31:0] mem [0:15];
   bit          have_aw, have_w, have_ar, b_fire_pend, r_fire_pend;
   bit          wr_outst, rd_outst, aw_track, w_track, stab_err;
   logic [31:0] aw_addr_c, w_data_c, ar_addr_c;
   aw_chan_t    aw_first;
   w_chan_t     w_first;
   int          aw_wait, aw_hi, w_hi, b_fires, proto_err;
   wr_t         exp_wr[$], obs_wr[$];
   logic [31:0] exp_rd[$], obs_rd[$];
   int          aw_cyc_q[$], w_cyc_q[$];

   bit          w0_seen;
   logic [31:0] w0_data;

   always #5 clk = ~clk;

   axi_lite_lfsr_mgr #(.NumTxns(4), .Seed(32'h0000_0001)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
      .err_cnt_o(err_cnt), .cycles_o(cycles), .req_o(req), .rsp_i(rsp)
   );

   axi_lite_lfsr_mgr #(.NumTxns(1), .Seed(32'h0000_0000)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .busy_o(busy0), .done_o(done0),
      .err_cnt_o(err_cnt0), .cycles_o(cycles0), .req_o(req0), .rsp_i(rsp0)
   );

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   // Memory responder: drives on the falling edge, so every decision made here completes at the next rising edge.
   always @(negedge clk) begin
      wr_t w;
      if (!rst_n) begin
         rsp = '0;
         have_aw = 0; have_w = 0; have_ar = 0; b_fire_pend = 0; r_fire_pend = 0;
         wr_outst = 0; rd_outst = 0; aw_track = 0; w_track = 0; aw_wait = 0;
      end else begin
         if (b_fire_pend) begin
            rsp.b_valid = 1'b0; b_fire_pend = 0; wr_outst = 0; b_fires++;
         end
         if (have_aw && have_w) begin
            mem[aw_addr_c[5:2]] = w_data_c;
            w.addr = aw_addr_c; w.data = w_data_c;
            obs_wr.push_back(w);
            rsp.b_valid = 1'b1;
            rsp.b.resp  = (slverr_b_en && aw_addr_c == slverr_b_addr) ? 2'b10 : 2'b00;
            have_aw = 0; have_w = 0;
         end
         if (rsp.b_valid && req.b_ready) b_fire_pend = 1;

         if (r_fire_pend) begin
            rsp.r_valid = 1'b0; r_fire_pend = 0; rd_outst = 0;
         end
         if (have_ar) begin
            rsp.r_valid = 1'b1;
            rsp.r.data  = mem[ar_addr_c[5:2]] ^ {31'b0, (corrupt_en && ar_addr_c == corrupt_addr)};
            rsp.r.resp  = (slverr_r_en && ar_addr_c == slverr_r_addr) ? 2'b10 : 2'b00;
            have_ar = 0;
         end
         if (rsp.r_valid && req.r_ready) r_fire_pend = 1;

         rsp.aw_ready = 1'b0;
         if (req.aw_valid) begin
            if (!aw_track) begin
               aw_track = 1; aw_first = req.aw; aw_hi = 0;
               if (wr_outst) proto_err++;
            end else if (req.aw !== aw_first) stab_err = 1;
            aw_hi++;
            if (aw_wait >= aw_delay) begin
               rsp.aw_ready = 1'b1; have_aw = 1; aw_addr_c = req.aw.addr; wr_outst = 1;
               aw_cyc_q.push_back(aw_hi); aw_track = 0; aw_wait = 0;
            end else aw_wait++;
         end

         rsp.w_ready = 1'b0;
         if (req.w_valid) begin
            if (!w_track) begin
               w_track = 1; w_first = req.w; w_hi = 0;
            end else if (req.w !== w_first) stab_err = 1;
            w_hi++;
            rsp.w_ready = 1'b1; have_w = 1; w_data_c = req.w.data;
            w_cyc_q.push_back(w_hi); w_track = 0;
         end

         rsp.ar_ready = 1'b0;
         if (req.ar_valid) begin
            if (rd_outst) proto_err++;
            rsp.ar_ready = 1'b1; have_ar = 1; ar_addr_c = req.ar.addr; rd_outst = 1;
            obs_rd.push_back(req.ar.addr);
         end
      end
   end

   // Second instance sees an always-ready, always-OKAY subordinate whose reads return 1.
   always @(negedge clk) begin
      if (req0.w_valid && !w0_seen) begin
         w0_seen = 1; w0_data = req0.w.data;
      end
   end

   task automatic clear_resp();
      aw_delay = 0; corrupt_en = 0; slverr_b_en = 0; slverr_r_en = 0;
      corrupt_addr = 32'h8; slverr_b_addr = 32'h4; slverr_r_addr = 32'hC;
      stab_err = 0; b_fires = 0; proto_err = 0; aw_wait = 0;
      exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
      aw_cyc_q.delete(); w_cyc_q.delete();
   endtask

   task automatic push_model_writes();
      logic [31:0] s = 32'h1;
      wr_t w;
      for (int i = 0; i < 4; i++) begin
         w.addr = 32'(i * 4); w.data = s;
         exp_wr.push_back(w);
         exp_rd.push_back(32'(i * 4));
         s = lfsr_step(s);
      end
   endtask

   task automatic applyStimulus(input bit extra_start, output int busy_n, output int done_n,
                                output bit timed_out);
      busy_n = 0; done_n = 0; timed_out = 1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 500; c++) begin
         if (busy) busy_n++;
         if (done) done_n++;
         start = extra_start && (c == 6);
         if (!busy && c > 0) begin timed_out = 0; break; end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start0 = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, busy0, done0} !== 4'b0)
         $display("[TB] FAIL reset_busy_done: got %b, expected 0000", {busy, done, busy0, done0});
      else n_pass++;
      n_checks++;
      if ({req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready} !== 5'b0)
         $display("[TB] FAIL reset_valids: got %b, expected 00000",
                  {req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready});
      else n_pass++;
      n_checks++;
      if (err_cnt !== 16'd0 || cycles !== 32'd0)
         $display("[TB] FAIL reset_counters: got err=%0d cycles=%0d, expected 0/0", err_cnt, cycles);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ideal();
      int busy_n, done_n; bit to; wr_t w, o; logic [31:0] a;
      clear_resp();
      w.addr = 32'h0; w.data = 32'h0000_0001; exp_wr.push_back(w);
      w.addr = 32'h4; w.data = 32'h8020_0003; exp_wr.push_back(w);
      w.addr = 32'h8; w.data = 32'hC030_0002; exp_wr.push_back(w);
      w.addr = 32'hC; w.data = 32'h6018_0001; exp_wr.push_back(w);
      exp_rd.push_back(32'h0); exp_rd.push_back(32'h4); exp_rd.push_back(32'h8); exp_rd.push_back(32'hC);
      applyStimulus(1'b1, busy_n, done_n, to);
      repeat (4) @(negedge clk);
      n_checks++;
      if (to) $display("[TB] FAIL ideal_timeout: got timeout, expected completion"); else n_pass++;
      n_checks++;
      if (done_n != 1) $display("[TB] FAIL ideal_done_pulses: got %0d, expected 1", done_n); else n_pass++;
      n_checks++;
      if (busy_n != 17) $display("[TB] FAIL ideal_busy_cycles: got %0d, expected 17", busy_n); else n_pass++;
      n_checks++;
      if (err_cnt !== 16'd0) $display("[TB] FAIL ideal_err_cnt: got %0d, expected 0", err_cnt); else n_pass++;
      n_checks++;
      if (obs_wr.size() != 4 || obs_rd.size() != 4 || busy !== 1'b0)
         $display("[TB] FAIL ideal_txn_count: got wr=%0d rd=%0d busy=%b, expected 4 4 0",
                  obs_wr.size(), obs_rd.size(), busy);
      else n_pass++;
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         w = exp_wr.pop_front(); o = obs_wr.pop_front();
         n_checks++;
         if (o !== w) $display("[TB] FAIL ideal_write: got %h:%h, expected %h:%h", o.addr, o.data, w.addr, w.data);
         else n_pass++;
      end
      while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
         a = exp_rd.pop_front();
         n_checks++;
         if (obs_rd[0] !== a) $display("[TB] FAIL ideal_read_addr: got %h, expected %h", obs_rd[0], a);
         else n_pass++;
         void'(obs_rd.pop_front());
      end
   endtask

   task automatic test_corrupt_read();
      int busy_n, done_n; bit to; wr_t w, o;
      clear_resp(); push_model_writes(); corrupt_en = 1;
      applyStimulus(1'b0, busy_n, done_n, to);
      n_checks++;
      if (to || err_cnt !== 16'd1)
         $display("[TB] FAIL corrupt_err_cnt: got %0d (timeout=%b), expected 1", err_cnt, to);
      else n_pass++;
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         w = exp_wr.pop_front(); o = obs_wr.pop_front();
         n_checks++;
         if (o !== w) $display("[TB] FAIL corrupt_write: got %h:%h, expected %h:%h", o.addr, o.data, w.addr, w.data);
         else n_pass++;
      end
   endtask

   task automatic test_slverr();
      int busy_n, done_n; bit to;
      clear_resp(); slverr_b_en = 1; slverr_r_en = 1;
      applyStimulus(1'b0, busy_n, done_n, to);
      n_checks++;
      if (to || err_cnt !== 16'd2)
         $display("[TB] FAIL slverr_err_cnt: got %0d (timeout=%b), expected 2", err_cnt, to);
      else n_pass++;
      repeat (5) @(negedge clk);
      n_checks++;
      if (err_cnt !== 16'd2) $display("[TB] FAIL slverr_err_hold: got %0d, expected 2", err_cnt); else n_pass++;
   endtask

   task automatic test_aw_delay();
      int busy_n, done_n; bit to;
      clear_resp(); aw_delay = 2;
      applyStimulus(1'b0, busy_n, done_n, to);
      n_checks++;
      if (to || aw_cyc_q.size() != 4 || w_cyc_q.size() != 4 || b_fires != 4)
         $display("[TB] FAIL awdly_counts: got aw=%0d w=%0d b=%0d (timeout=%b), expected 4 4 4",
                  aw_cyc_q.size(), w_cyc_q.size(), b_fires, to);
      else n_pass++;
      foreach (aw_cyc_q[i]) begin
         n_checks++;
         if (aw_cyc_q[i] != 3 || w_cyc_q[i] != 1)
            $display("[TB] FAIL awdly_valid_len: got aw=%0d w=%0d, expected 3 1", aw_cyc_q[i], w_cyc_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (stab_err || proto_err != 0 || err_cnt !== 16'd0)
         $display("[TB] FAIL awdly_protocol: got stab=%b proto=%0d err=%0d, expected 0 0 0",
                  stab_err, proto_err, err_cnt);
      else n_pass++;
   endtask

   task automatic test_seed0_perf();
      int busy_n = 0, done_n = 0; bit to = 1;
      logic [31:0] want_cycles;
      w0_seen = 0;
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (busy0) busy_n++;
         if (done0) done_n++;
         if (!busy0 && c > 0) begin to = 0; break; end
         @(negedge clk);
      end
      n_checks++;
      if (!w0_seen || w0_data !== 32'h0000_0001)
         $display("[TB] FAIL seed0_first_data: got %h (seen=%b), expected 00000001", w0_data, w0_seen);
      else n_pass++;
      n_checks++;
      if (to || done_n != 1 || busy_n != 5 || err_cnt0 !== 16'd0)
         $display("[TB] FAIL seed0_run: got done=%0d busy=%0d err=%0d, expected 1 5 0", done_n, busy_n, err_cnt0);
      else n_pass++;
`ifdef AXI_LITE_LFSR_MGR_PERF_EN
      want_cycles = 32'(busy_n);
`else
      want_cycles = 32'd0;
`endif
      n_checks++;
      if (cycles0 !== want_cycles)
         $display("[TB] FAIL perf_cycles: got %0d, expected %0d", cycles0, want_cycles);
      else n_pass++;
   endtask

   task automatic checkOutput();
      n_checks++;
      if ({req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready} !== 5'b0 || busy !== 1'b0)
         $display("[TB] FAIL midrun_reset_async: got valids=%b busy=%b, expected 00000 0",
                  {req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready}, busy);
      else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      bit seen = 0;
      clear_resp(); aw_delay = 6;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (req.aw_valid) begin seen = 1; break; end
         @(negedge clk);
      end
      n_checks++;
      if (!seen) $display("[TB] FAIL midrun_aw_seen: got no aw_valid, expected aw_valid"); else n_pass++;
      #2 rst_n = 1'b0;
      #1 checkOutput();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || err_cnt !== 16'd0)
         $display("[TB] FAIL midrun_after_reset: got busy=%b err=%0d, expected 0 0", busy, err_cnt);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int busy_n, done_n; bit to;
      clear_resp();
      applyStimulus(1'b0, busy_n, done_n, to);
      n_checks++;
      if (to || done_n != 1 || err_cnt !== 16'd0 || obs_wr.size() != 4)
         $display("[TB] FAIL recovery_run: got done=%0d err=%0d wr=%0d, expected 1 0 4", done_n, err_cnt, obs_wr.size());
      else n_pass++;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rsp = '0; rsp0 = '0;
      rsp0.aw_ready = 1'b1; rsp0.w_ready = 1'b1; rsp0.b_valid = 1'b1;
      rsp0.ar_ready = 1'b1; rsp0.r_valid = 1'b1; rsp0.r.data = 32'h0000_0001;
      foreach (mem[i]) mem[i] = 32'h0;
      clear_resp();
      test_reset();
      test_ideal();
      test_corrupt_read();
      test_slverr();
      test_aw_delay();
      test_seed0_perf();
      test_reset_mid_run();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
